// File: rtl/sram_rw_port_arbiter_if.sv
// Requester A/B command and response buses plus RW-port macro pins.
// The slave modport is the arbiter's view; master is the surrounding tile/bench view.
interface sram_rw_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
);
  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [NUM_WMASKS-1:0] a_wmask;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [NUM_WMASKS-1:0] b_wmask;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  init_done;

  modport slave (
    input  a_valid, a_we, a_wmask, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_wmask, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    output csb0, web0, wmask0, addr0, din0,
    input  dout0,
    output init_done
  );

  modport master (
    output a_valid, a_we, a_wmask, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_wmask, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    input  csb0, web0, wmask0, addr0, din0,
    output dout0,
    input  init_done
  );
endinterface

// File: rtl/sram_rw_port_arbiter.sv
// Round-robin share of the SRAM RW port between requesters A and B, with optional zero-fill.
// Macro pins are registered at the grant edge; read data returns READ_LATENCY+1 edges later.
module sram_rw_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_WMASKS     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_rw_port_arbiter_if.slave    bus
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic vld;
    logic id;    // 0 = A, 1 = B
  } tag_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   fill_addr;
  logic [ADDR_WIDTH-1:0]   fill_addr_nxt;
  logic                    fill_we;
  logic                    init_done_q;

  logic                    ptr;       // 0: A wins a tie, 1: B wins a tie
  logic                    a_rdy;
  logic                    b_rdy;
  logic                    a_grant;
  logic                    b_grant;

  logic                    csb0_q;
  logic                    web0_q;
  logic [NUM_WMASKS-1:0]   wmask0_q;
  logic [ADDR_WIDTH-1:0]   addr0_q;
  logic [DATA_WIDTH-1:0]   din0_q;

  tag_t                    tag_in;
  tag_t [READ_LATENCY:0]   tag_q;
  tag_t                    tag_out;

  logic                    a_rvalid_q;
  logic                    b_rvalid_q;
  logic [DATA_WIDTH-1:0]   a_rdata_q;
  logic [DATA_WIDTH-1:0]   b_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      fill_addr   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      fill_addr   <= fill_addr_nxt;
      init_done_q <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt     = state;
    fill_addr_nxt = fill_addr;
    fill_we       = 1'b0;
    case (state)
      INIT: begin
        if (CLEAR_ON_RESET != 0) begin
          fill_we       = 1'b1;
          fill_addr_nxt = fill_addr + 1'b1;
          if (fill_addr == {ADDR_WIDTH{1'b1}}) state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Each ready ignores its own valid so that a requester can sample it before committing.
  assign a_rdy   = (state == RUN) && (!bus.b_valid || !ptr);
  assign b_rdy   = (state == RUN) && (!bus.a_valid ||  ptr);
  assign a_grant = bus.a_valid && a_rdy;
  assign b_grant = bus.b_valid && b_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (a_grant) begin
      ptr <= 1'b1;
    end else if (b_grant) begin
      ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
    end else if (fill_we) begin
      csb0_q   <= 1'b0;
      web0_q   <= 1'b0;
      wmask0_q <= '1;
      addr0_q  <= fill_addr;
      din0_q   <= '0;
    end else if (a_grant) begin
      csb0_q   <= 1'b0;
      web0_q   <= !bus.a_we;
      wmask0_q <= bus.a_wmask;
      addr0_q  <= bus.a_addr;
      din0_q   <= bus.a_wdata;
    end else if (b_grant) begin
      csb0_q   <= 1'b0;
      web0_q   <= !bus.b_we;
      wmask0_q <= bus.b_wmask;
      addr0_q  <= bus.b_addr;
      din0_q   <= bus.b_wdata;
    end else begin
      // Address/data/mask hold to avoid needless toggling on the macro pins.
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
    end
  end

  assign tag_in  = {(a_grant && !bus.a_we) || (b_grant && !bus.b_we), b_grant};
  assign tag_out = tag_q[READ_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k <= READ_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= tag_out.vld && !tag_out.id;
      b_rvalid_q <= tag_out.vld &&  tag_out.id;
      if (tag_out.vld && !tag_out.id) a_rdata_q <= bus.dout0;
      if (tag_out.vld &&  tag_out.id) b_rdata_q <= bus.dout0;
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.csb0      = csb0_q;
  assign bus.web0      = web0_q;
  assign bus.wmask0    = wmask0_q;
  assign bus.addr0     = addr0_q;
  assign bus.din0      = din0_q;
  assign bus.init_done = init_done_q;

endmodule
